// File: rtl/burst_adaptor_pkg.sv
// Shared types, default widths and address helper for the line-to-burst adaptor.
package burst_adaptor_pkg;

    // Adaptor FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } adaptor_state_e;

    // Default geometry: 256-bit cache line, 64-bit memory beat, 32-bit byte address.
    localparam int unsigned DEF_LINE_W  = 32'd256;
    localparam int unsigned DEF_BURST_W = 32'd64;
    localparam int unsigned DEF_ADDR_W  = 32'd32;

    // Widest address the alignment helper handles.
    localparam int unsigned MAX_ADDR_W  = 32'd64;

    // Clear the low ofs_w bits so the address points at the start of its line.
    function automatic logic [MAX_ADDR_W-1:0] align_addr(
        input logic [MAX_ADDR_W-1:0] addr,
        input int unsigned           ofs_w
    );
        logic [MAX_ADDR_W-1:0] mask;
        mask = ~((64'd1 << ofs_w) - 64'd1);
        return addr & mask;
    endfunction

endpackage

// File: rtl/burst_line_adaptor.sv
// Converts one cache-line read or write into BEATS ascending memory beats and
// returns a single completion pulse. Writes win over a simultaneous read; the
// read stays pending and is taken in the first IDLE cycle after the write.
module burst_line_adaptor
    import burst_adaptor_pkg::*;
#(
    parameter int unsigned LINE_W  = DEF_LINE_W,
    parameter int unsigned BURST_W = DEF_BURST_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    output logic               busy_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int unsigned BEATS = LINE_W / BURST_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFS_W = $clog2(LINE_W / 8);

    // The beat counter wraps by overflow, so the beat count must be a power of two.
    if (((LINE_W % BURST_W) != 0) || (BEATS < 2) || ((BEATS & (BEATS - 1)) != 0)) begin : g_param_check
        $error("burst_line_adaptor: LINE_W must be BURST_W times a power of two >= 2");
    end

    adaptor_state_e      state_r;
    adaptor_state_e      state_nx_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [LINE_W-1:0]   line_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [ADDR_W-1:0]   aligned_s;
    logic                last_beat_s;

    assign aligned_s   = ADDR_W'(align_addr(MAX_ADDR_W'(address_i), OFS_W));
    assign last_beat_s = (cnt_r == CNT_W'(BEATS - 1));

    // Next-state decode; write has priority over read when both are pending.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (write_i) begin
                    state_nx_s = WR;
                end else if (read_i) begin
                    state_nx_s = RD;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RD, WR: begin
                if (resp_i && last_beat_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = state_r;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State, beat counter and the shared line/address holding registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            line_r  <= '0;
            addr_r  <= '0;
        end else begin
            state_r <= state_nx_s;
            case (state_r)
                IDLE: begin
                    if (write_i) begin
                        line_r <= line_i;
                        addr_r <= aligned_s;
                        cnt_r  <= '0;
                    end else if (read_i) begin
                        addr_r <= aligned_s;
                        cnt_r  <= '0;
                    end
                end
                RD: begin
                    if (resp_i) begin
                        line_r[int'(cnt_r)*BURST_W +: BURST_W] <= burst_i;
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                WR: begin
                    if (resp_i) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Memory strobes, write beat and completion pulse decoded from the state register.
    always_comb begin
        read_o  = 1'b0;
        write_o = 1'b0;
        resp_o  = 1'b0;
        burst_o = '0;
        case (state_r)
            RD:   read_o = 1'b1;
            WR: begin
                write_o = 1'b1;
                burst_o = line_r[int'(cnt_r)*BURST_W +: BURST_W];
            end
            DONE: resp_o = 1'b1;
            default: begin
            end
        endcase
    end

    assign busy_o    = (state_r != IDLE);
    assign address_o = addr_r;
    assign line_o    = line_r;

endmodule

// File: tb/tb_burst_line_adaptor.sv
// Scoreboard bench for burst_line_adaptor: a default 4-beat instance and a
// 512-bit 8-beat instance share the memory-side inputs; only the instance
// whose request is raised ever leaves IDLE.
module tb_burst_line_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  address_i;
    logic         resp_i;
    logic [63:0]  burst_i;

    logic [255:0] line_ia, line_oa;
    logic         read_a, write_a, resp_oa, busy_oa, read_oa, write_oa;
    logic [63:0]  burst_oa;
    logic [31:0]  addr_oa;

    logic [511:0] line_ib, line_ob;
    logic         read_b, write_b, resp_ob, busy_ob, read_ob, write_ob;
    logic [63:0]  burst_ob;
    logic [31:0]  addr_ob;

    int n_cmp = 0;
    int n_err = 0;

    logic [511:0] qa[$];
    logic [511:0] qb[$];

    logic [63:0] ra[8], wb[8], wc[8], rc[8], rz[8], rd[8], bb[8];

    burst_line_adaptor u_dut_a (
        .clk(clk), .rst(rst), .line_i(line_ia), .line_o(line_oa),
        .address_i(address_i), .read_i(read_a), .write_i(write_a),
        .resp_o(resp_oa), .busy_o(busy_oa), .burst_i(burst_i), .burst_o(burst_oa),
        .address_o(addr_oa), .read_o(read_oa), .write_o(write_oa), .resp_i(resp_i)
    );

    burst_line_adaptor #(.LINE_W(512), .BURST_W(64), .ADDR_W(32)) u_dut_b (
        .clk(clk), .rst(rst), .line_i(line_ib), .line_o(line_ob),
        .address_i(address_i), .read_i(read_b), .write_i(write_b),
        .resp_o(resp_ob), .busy_o(busy_ob), .burst_i(burst_i), .burst_o(burst_ob),
        .address_o(addr_ob), .read_o(read_ob), .write_o(write_ob), .resp_i(resp_i)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor for the default instance: each completion pulse pops one expected line.
    always @(negedge clk) begin
        if (!rst && resp_oa) begin
            if (qa.size() == 0) begin
                chk("unexpected_resp_a", resp_oa, 512'd0);
            end else begin
                chk("line_o_a", line_oa, qa.pop_front());
            end
        end
    end

    // Scoreboard monitor for the 8-beat instance.
    always @(negedge clk) begin
        if (!rst && resp_ob) begin
            if (qb.size() == 0) begin
                chk("unexpected_resp_b", resp_ob, 512'd0);
            end else begin
                chk("line_o_b", line_ob, qb.pop_front());
            end
        end
    end

    // Memory side of one burst, starting in the cycle after acceptance.
    task automatic serve(input int sel, input bit is_wr, input int nb, input logic [63:0] d[8],
                         input int stall, input logic [31:0] exp_addr,
                         output int strobes, output int resp_cyc);
        int cyc;
        logic st, ro;
        logic [63:0] bo;
        logic [31:0] ao;
        cyc = 1;
        strobes = 0;
        resp_cyc = -1;
        for (int b = 0; b < nb; b++) begin
            for (int s = 0; s <= stall; s++) begin
                resp_i  = (s == stall);
                burst_i = is_wr ? 64'd0 : ((s == stall) ? d[b] : 64'hBAD0_BAD0_BAD0_BAD0);
                st = (sel == 0) ? (is_wr ? write_oa : read_oa) : (is_wr ? write_ob : read_ob);
                bo = (sel == 0) ? burst_oa : burst_ob;
                ao = (sel == 0) ? addr_oa : addr_ob;
                ro = (sel == 0) ? resp_oa : resp_ob;
                if (st) strobes++;
                chk("address_o", ao, exp_addr);
                chk("resp_o_busy", ro, 512'd0);
                if (is_wr) chk("burst_o", bo, d[b]);
                step();
                cyc++;
            end
        end
        resp_i  = 1'b0;
        burst_i = 64'd0;
        st = (sel == 0) ? (read_oa | write_oa) : (read_ob | write_ob);
        ro = (sel == 0) ? resp_oa : resp_ob;
        bo = (sel == 0) ? burst_oa : burst_ob;
        chk("strobe_in_done", st, 512'd0);
        chk("burst_o_done", bo, 512'd0);
        chk("resp_o_done", ro, 512'd1);
        if (ro) resp_cyc = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        int strobes, rc_cyc;
        ra = '{64'hAAAAAAAAAAAAAAA0, 64'hAAAAAAAAAAAAAAA1, 64'hAAAAAAAAAAAAAAA2, 64'hAAAAAAAAAAAAAAA3,
               64'd0, 64'd0, 64'd0, 64'd0};
        wb = '{64'h8796A5B4C3D2E1F0, 64'h0F1E2D3C4B5A6978, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF,
               64'd0, 64'd0, 64'd0, 64'd0};
        wc = '{64'h0000000000000000, 64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333,
               64'd0, 64'd0, 64'd0, 64'd0};
        rc = '{64'hC0C0C0C0C0C0C0C0, 64'hC1C1C1C1C1C1C1C1, 64'hC2C2C2C2C2C2C2C2, 64'hC3C3C3C3C3C3C3C3,
               64'd0, 64'd0, 64'd0, 64'd0};
        rz = '{64'hDEADBEEF00000000, 64'hDEADBEEF00000001, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
        rd = '{64'h00000000000000D0, 64'h00000000000000D1, 64'h00000000000000D2, 64'h00000000000000D3,
               64'd0, 64'd0, 64'd0, 64'd0};
        bb = '{64'h00000000000000B0, 64'h00000000000000B1, 64'h00000000000000B2, 64'h00000000000000B3,
               64'h00000000000000B4, 64'h00000000000000B5, 64'h00000000000000B6, 64'h00000000000000B7};

        rst = 1'b1;
        address_i = 32'd0; resp_i = 1'b0; burst_i = 64'd0;
        line_ia = '0; read_a = 1'b0; write_a = 1'b0;
        line_ib = '0; read_b = 1'b0; write_b = 1'b0;
        step();
        step();
        chk("rst_busy", busy_oa, 512'd0);
        chk("rst_strobes", {read_oa, write_oa, resp_oa}, 512'd0);
        chk("rst_line_o", line_oa, 512'd0);
        chk("rst_address_o", addr_oa, 512'd0);
        chk("rst_burst_o", burst_oa, 512'd0);
        rst = 1'b0;
        step();

        // Read, resp_i every cycle.
        read_a = 1'b1; address_i = 32'h1000_0024;
        qa.push_back(512'hAAAAAAAAAAAAAAA3_AAAAAAAAAAAAAAA2_AAAAAAAAAAAAAAA1_AAAAAAAAAAAAAAA0);
        step();
        chk("rd_busy", busy_oa, 512'd1);
        serve(0, 1'b0, 4, ra, 0, 32'h1000_0020, strobes, rc_cyc);
        chk("rd_strobe_cycles", strobes, 512'd4);
        chk("rd_resp_latency", rc_cyc, 512'd5);
        step();
        read_a = 1'b0;
        step();
        chk("rd_line_held", line_oa, 512'hAAAAAAAAAAAAAAA3_AAAAAAAAAAAAAAA2_AAAAAAAAAAAAAAA1_AAAAAAAAAAAAAAA0);
        chk("rd_idle", busy_oa, 512'd0);

        // Write with two stall cycles before each beat; inputs change after acceptance.
        write_a = 1'b1; address_i = 32'h3000_001F;
        line_ia = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
        qa.push_back(512'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0);
        step();
        line_ia = {4{64'h5A5A5A5A5A5A5A5A}};
        address_i = 32'hFFFF_FFFF;
        serve(0, 1'b1, 4, wb, 2, 32'h3000_0000, strobes, rc_cyc);
        chk("wr_strobe_cycles", strobes, 512'd12);
        chk("wr_resp_latency", rc_cyc, 512'd13);
        step();
        write_a = 1'b0;
        step();

        // Simultaneous read and write: write first, read taken in the next IDLE cycle.
        read_a = 1'b1; write_a = 1'b1; address_i = 32'h5000_0008;
        line_ia = 256'h3333333333333333_2222222222222222_1111111111111111_0000000000000000;
        qa.push_back(512'h3333333333333333_2222222222222222_1111111111111111_0000000000000000);
        qa.push_back(512'hC3C3C3C3C3C3C3C3_C2C2C2C2C2C2C2C2_C1C1C1C1C1C1C1C1_C0C0C0C0C0C0C0C0);
        step();
        chk("both_write_first", {read_oa, write_oa}, 512'b01);
        serve(0, 1'b1, 4, wc, 0, 32'h5000_0000, strobes, rc_cyc);
        chk("both_wr_latency", rc_cyc, 512'd5);
        step();
        write_a = 1'b0;
        chk("both_idle_between", busy_oa, 512'd0);
        step();
        serve(0, 1'b0, 4, rc, 0, 32'h5000_0000, strobes, rc_cyc);
        chk("both_rd_strobe_cycles", strobes, 512'd4);
        chk("both_rd_latency", rc_cyc, 512'd5);
        step();
        read_a = 1'b0;
        step();

        // Asynchronous reset mid-read after two beats.
        read_a = 1'b1; address_i = 32'h4000_0010;
        step();
        resp_i = 1'b1; burst_i = rz[0];
        step();
        burst_i = rz[1];
        step();
        resp_i = 1'b0; burst_i = 64'd0;
        chk("pre_rst_read_o", read_oa, 512'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_read_o", read_oa, 512'd0);
        chk("mid_rst_write_o", write_oa, 512'd0);
        chk("mid_rst_line_o", line_oa, 512'd0);
        chk("mid_rst_busy", busy_oa, 512'd0);
        chk("mid_rst_resp_o", resp_oa, 512'd0);
        chk("mid_rst_address_o", addr_oa, 512'd0);
        read_a = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        step();
        step();
        chk("post_rst_idle", busy_oa, 512'd0);

        // Normal read after reset.
        read_a = 1'b1; address_i = 32'h4000_0010;
        qa.push_back(512'h00000000000000D3_00000000000000D2_00000000000000D1_00000000000000D0);
        step();
        serve(0, 1'b0, 4, rd, 0, 32'h4000_0000, strobes, rc_cyc);
        chk("post_rst_rd_latency", rc_cyc, 512'd5);
        step();
        read_a = 1'b0;
        step();

        // 512-bit line, 8 beats, on the second instance.
        read_b = 1'b1; address_i = 32'h2000_007F;
        qb.push_back({64'h00000000000000B7, 64'h00000000000000B6, 64'h00000000000000B5, 64'h00000000000000B4,
                      64'h00000000000000B3, 64'h00000000000000B2, 64'h00000000000000B1, 64'h00000000000000B0});
        step();
        serve(1, 1'b0, 8, bb, 0, 32'h2000_0040, strobes, rc_cyc);
        chk("b8_strobe_cycles", strobes, 512'd8);
        chk("b8_resp_latency", rc_cyc, 512'd9);
        step();
        read_b = 1'b0;
        step();
        chk("b8_idle", busy_ob, 512'd0);
        step();

        chk("qa_drained", qa.size(), 512'd0);
        chk("qb_drained", qb.size(), 512'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
